weight_tile_loader: RTL and testbench

Upstream feeder for the Weight FIFO. It accepts weight rows one at a time over a narrow valid/ready stream, one row being `MATRIX_SIZE` weights. It assembles `NUM_PE_ROWS` rows into one full weight tile, then pushes the whole tile into the Weight FIFO with a single `fifo_write_enable` pulse, stalling while the FIFO is full. Short tiles, terminated early with `in_last`, are zero-padded, so the FIFO always receives complete tiles.

---
 rtl/weight_tile_loader.sv | 98 +++++++++
 tb/tb_weight_tile_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_loader.sv
// Collects weight rows from a valid/ready stream into a full tile, then pushes the
// tile to the Weight FIFO with a single strobe. Short tiles are zero-padded.
`timescale 1ns/1ps
module weight_tile_loader #(
    parameter int WEIGHT_BW   = 8,
    parameter int MATRIX_SIZE = 64,
    parameter int NUM_PE_ROWS = 64,
    parameter int ROW_IDX_BW  = 6
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       flush,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0]           in_row,
    input  logic                                       in_last,
    input  logic                                       fifo_full,
    output logic                                       fifo_write_enable,
    output logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data_in,
    output logic [7:0]                                 tile_count,
    output logic                                       err_len,
    output logic                                       busy
);

    localparam int ROW_W  = WEIGHT_BW * MATRIX_SIZE;
    localparam int TILE_W = ROW_W * NUM_PE_ROWS;
    localparam logic [ROW_IDX_BW-1:0] LAST_ROW = ROW_IDX_BW'(NUM_PE_ROWS - 1);

    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ROW_IDX_BW-1:0]   row_idx_q;
    logic [ROW_IDX_BW-1:0]   row_idx_d;
    logic [TILE_W-1:0]       tile_q;
    logic [7:0]              tile_count_q;
    logic [7:0]              tile_count_d;
    logic                    err_len_q;
    logic                    accept;
    logic                    row_final;
    logic                    push;

    // in_ready comes from state alone, so no combinational path from in_valid or fifo_full.
    assign in_ready     = (state_q == FILL);
    assign accept       = in_valid & in_ready;
    assign row_final    = (row_idx_q == LAST_ROW);
    assign push         = (state_q == PUSH) & ~fifo_full & ~flush;
    assign row_idx_d    = row_idx_q + 1'b1;
    assign tile_count_d = tile_count_q + 8'd1;

    assign fifo_write_enable = push;
    assign fifo_data_in      = tile_q;
    assign tile_count        = tile_count_q;
    assign err_len           = err_len_q;
    assign busy              = (state_q == PUSH) | (row_idx_q != '0);

    // NOTE: all state here updates with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL;
            row_idx_q    <= '0;
            // NOTE: the tile store is reset on purpose; it drives fifo_data_in directly and
            // unfilled rows must read as zero padding.
            tile_q       <= '0;
            tile_count_q <= '0;
            err_len_q    <= 1'b0;
        end else if (flush) begin
            state_q   <= FILL;
            row_idx_q <= '0;
            tile_q    <= '0;
            err_len_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        tile_q[int'(row_idx_q)*ROW_W +: ROW_W] <= in_row;
                        row_idx_q <= row_idx_d;
                        if (in_last || row_final) state_q <= PUSH;
                        // A full tile without in_last is still pushed, but flagged.
                        if (!in_last && row_final) err_len_q <= 1'b1;
                    end
                end
                PUSH: begin
                    if (push) begin
                        state_q      <= FILL;
                        row_idx_q    <= '0;
                        tile_q       <= '0;
                        tile_count_q <= tile_count_d;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: full, streamed, short and stalled tiles,
// missing-last error, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_weight_tile_loader;

    localparam int WEIGHT_BW   = 8;
    localparam int MATRIX_SIZE = 64;
    localparam int NUM_PE_ROWS = 64;
    localparam int ROW_IDX_BW  = 6;
    localparam int RW          = WEIGHT_BW * MATRIX_SIZE;
    localparam int TW          = RW * NUM_PE_ROWS;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          in_last;
    logic          fifo_full;
    logic          fifo_write_enable;
    logic [TW-1:0] fifo_data_in;
    logic [7:0]    tile_count;
    logic          err_len;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobe_cnt = 0;
    int strobe_cyc[$];
    logic [RW-1:0] exp_tile [NUM_PE_ROWS];

    weight_tile_loader #(
        .WEIGHT_BW  (WEIGHT_BW),
        .MATRIX_SIZE(MATRIX_SIZE),
        .NUM_PE_ROWS(NUM_PE_ROWS),
        .ROW_IDX_BW (ROW_IDX_BW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_row           (in_row),
        .in_last          (in_last),
        .fifo_full        (fifo_full),
        .fifo_write_enable(fifo_write_enable),
        .fifo_data_in     (fifo_data_in),
        .tile_count       (tile_count),
        .err_len          (err_len),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn && fifo_write_enable) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
        strobe_cyc.delete();
    endtask

    task automatic clear_exp();
        for (int r = 0; r < NUM_PE_ROWS; r++) exp_tile[r] = '0;
    endtask

    // Presents one row and holds it until accepted; returns accept cycle and stall count.
    task automatic send_row(input logic [RW-1:0] row, input logic last,
                            output int acc, output int waits);
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 300) begin
            next_cycle();
            @(negedge clk);
            waits++;
        end
        if (waits >= 300) check("ready_timeout", 1'b0, 1'b1);
        acc = cyc;
        next_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = '1;
    endtask

    task automatic send_tile(input int n, input int base, input int step, input bit with_last,
                             output int first_acc, output int first_wait);
        logic [WEIGHT_BW-1:0] b;
        int acc;
        int waits;
        for (int r = 0; r < n; r++) begin
            b = WEIGHT_BW'(base + r * step);
            exp_tile[r] = {MATRIX_SIZE{b}};
            send_row({MATRIX_SIZE{b}}, with_last && (r == n - 1), acc, waits);
            if (r == 0) begin
                first_acc  = acc;
                first_wait = waits;
            end
        end
    endtask

    // Waits (bounded) for the push strobe and compares every row of the pushed tile.
    task automatic wait_strobe(input string tag, output int waited);
        waited = 0;
        @(negedge clk);
        while (!fifo_write_enable && waited < 300) begin
            next_cycle();
            @(negedge clk);
            waited++;
        end
        check({tag, "_strobe"}, RW'(fifo_write_enable), RW'(1));
        for (int r = 0; r < NUM_PE_ROWS; r++)
            check($sformatf("%s_row%0d", tag, r), fifo_data_in[r*RW +: RW], exp_tile[r]);
        next_cycle();
    endtask

    task automatic check_idle(input string tag, input int exp_count, input logic exp_err);
        check({tag, "_ready"}, RW'(in_ready), RW'(1));
        check({tag, "_busy"},  RW'(busy), RW'(0));
        check({tag, "_data0"}, RW'(fifo_data_in == '0), RW'(1));
        check({tag, "_count"}, RW'(tile_count), RW'(exp_count));
        check({tag, "_err"},   RW'(err_len), RW'(exp_err));
    endtask

    initial begin
        int acc0, w0, waited, cnt_before, dummy;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_we", RW'(fifo_write_enable), RW'(0));
        check_idle("rst", 0, 1'b0);
        next_cycle();

        // Full tile, row r = all (r+1), in_last on row 63
        clear_exp();
        send_tile(64, 1, 1, 1'b1, acc0, w0);
        wait_strobe("full", waited);
        check("full_wait", RW'(waited), RW'(0));
        check("full_latency", RW'(strobe_cyc[strobe_cyc.size()-1] - acc0), RW'(64));
        check_idle("full_after", 1, 1'b0);

        // Two tiles streamed back to back
        do_reset();
        clear_exp();
        send_tile(64, 1, 1, 1'b1, acc0, w0);
        send_tile(64, 8'h80, 1, 1'b1, acc0, w0);
        check("stream_gap", RW'(w0), RW'(1));
        wait_strobe("stream", waited);
        check("stream_nstrobes", RW'(strobe_cyc.size()), RW'(2));
        check("stream_spacing", RW'(strobe_cyc[1] - strobe_cyc[0]), RW'(65));
        check("stream_count", RW'(tile_count), RW'(2));

        // Short tile: 0x11, 0x22, 0x33 then zero padding
        clear_exp();
        send_tile(3, 8'h11, 8'h11, 1'b1, acc0, w0);
        check("short_busy", RW'(busy), RW'(1));
        wait_strobe("short", waited);
        check_idle("short_after", 3, 1'b0);

        // FIFO full for 10 cycles after completion; junk rows offered meanwhile
        clear_exp();
        fifo_full = 1'b1;
        send_tile(2, 8'h05, 8'h05, 1'b1, acc0, w0);
        cnt_before = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_row   = {MATRIX_SIZE{8'hEE}};
            @(negedge clk);
            check($sformatf("stall%0d_we", i), RW'(fifo_write_enable), RW'(0));
            check($sformatf("stall%0d_ready", i), RW'(in_ready), RW'(0));
            check($sformatf("stall%0d_row0", i), fifo_data_in[0 +: RW], exp_tile[0]);
            check($sformatf("stall%0d_row1", i), fifo_data_in[RW +: RW], exp_tile[1]);
            next_cycle();
        end
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        wait_strobe("stall", waited);
        check("stall_wait", RW'(waited), RW'(0));
        repeat (3) next_cycle();
        check("stall_one_strobe", RW'(strobe_cnt - cnt_before), RW'(1));
        check_idle("stall_after", 4, 1'b0);

        // 64 rows without in_last: pushed, err_len sticky until flush
        clear_exp();
        send_tile(64, 8'h40, 1, 1'b0, acc0, w0);
        wait_strobe("nolast", waited);
        check("nolast_err", RW'(err_len), RW'(1));
        clear_exp();
        send_tile(1, 8'h77, 1, 1'b1, acc0, w0);
        wait_strobe("sticky", waited);
        check_idle("sticky_after", 6, 1'b1);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check_idle("flush_err", 6, 1'b0);

        // Flush after 20 rows, with a row offered in the same cycle
        clear_exp();
        send_tile(20, 8'h90, 1, 1'b0, acc0, w0);
        check("f20_busy", RW'(busy), RW'(1));
        cnt_before = strobe_cnt;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_row   = {MATRIX_SIZE{8'hAB}};
        @(negedge clk);
        check("f20_we", RW'(fifo_write_enable), RW'(0));
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_idle("f20_after", 6, 1'b0);

        // Flush while in PUSH with FIFO ready: strobe suppressed
        send_tile(2, 8'hA0, 1, 1'b1, acc0, w0);
        flush = 1'b1;
        @(negedge clk);
        check("fpush_we", RW'(fifo_write_enable), RW'(0));
        next_cycle();
        flush = 1'b0;
        check_idle("fpush_after", 6, 1'b0);
        check("flush_nostrobe", RW'(strobe_cnt - cnt_before), RW'(0));

        // Async reset mid-PUSH with FIFO full and err_len set
        fifo_full = 1'b1;
        send_tile(64, 8'h10, 1, 1'b0, acc0, dummy);
        check("arst_pre_err", RW'(err_len), RW'(1));
        check("arst_pre_busy", RW'(busy), RW'(1));
        cnt_before = strobe_cnt;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_we", RW'(fifo_write_enable), RW'(0));
        check_idle("arst", 0, 1'b0);
        @(negedge clk);
        rstn      = 1'b1;
        fifo_full = 1'b0;
        repeat (3) next_cycle();
        check("arst_nostrobe", RW'(strobe_cnt - cnt_before), RW'(0));
        check_idle("arst_after", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
